// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Reads a burst of Len consecutive words from a synchronous ROM starting at
//   BaseAdr and streams them out over a valid/ready port, keeping at most two
//   words (buffered plus in flight) ahead of the consumer.
//
// Optional feature:
//   ROMREADER_CHECKSUM_EN - when defined, Checksum accumulates the modulo-2^DATA_BITS
//   sum of words transferred in the current/last burst; otherwise Checksum is 0.
//
// Ports:
//   clk, resetn          clock; asynchronous active-low reset
//   Start/BaseAdr/Len    burst request, sampled only while idle
//   Busy, Done           burst in progress; one-cycle completion pulse
//   RomCEB/RomA/RomQ     ROM read port (RomQ valid the cycle after RomCEB low)
//   OutValid/OutData/OutLast/OutReady   output stream
//   Checksum             running sum of transferred words
//   DbgState             current FSM state for observation
//
// Handshake: a word transfers on a rising edge where OutValid and OutReady are
// both high; once OutValid is raised, OutValid and OutData hold until transfer.
module rom_stream_reader #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 Start,
    input  logic [ADDR_BITS-1:0] BaseAdr,
    input  logic [ADDR_BITS:0]   Len,
    output logic                 Busy,
    output logic                 Done,
    output logic                 RomCEB,
    output logic [ADDR_BITS-1:0] RomA,
    input  logic [DATA_BITS-1:0] RomQ,
    output logic                 OutValid,
    output logic [DATA_BITS-1:0] OutData,
    output logic                 OutLast,
    input  logic                 OutReady,
    output logic [DATA_BITS-1:0] Checksum,
    output logic [1:0]           DbgState
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_BITS-1:0] ONE_A = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   ONE_L = {{ADDR_BITS{1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [ADDR_BITS:0]     rem_q, rem_d;          // reads still to issue
    logic [ADDR_BITS:0]     out_rem_q, out_rem_d;  // words still to transfer
    logic                   done_q, done_d;
    logic                   pend_q, pend_d;        // read issued last edge, data on RomQ now
    logic [1:0]             cnt_q, cnt_d;          // FIFO occupancy
    logic [DATA_BITS-1:0]   s0_q, s0_d;            // FIFO head (drives OutData)
    logic [DATA_BITS-1:0]   s1_q, s1_d;

    logic [2:0] occ;
    logic       pop;
    logic       room;
    logic       issue;

    always_comb begin
        occ   = {1'b0, cnt_q} + {2'b00, pend_q};
        pop   = (cnt_q != 2'd0) && OutReady;
        // A new read's data lands one edge later; counting this cycle's pop
        // lets the pipeline run at one word per cycle without overfilling.
        room  = (occ < 3'd2) || ((occ == 3'd2) && pop);
        issue = (state_q == S_READ) && room;

        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        out_rem_d = out_rem_q;
        done_d    = 1'b0;
        pend_d    = issue;
        cnt_d     = cnt_q;
        s0_d      = s0_q;
        s1_d      = s1_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Len != '0) begin
                        state_d   = S_READ;
                        addr_d    = BaseAdr;
                        rem_d     = Len;
                        out_rem_d = Len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d = addr_q + ONE_A;  // wraps modulo 2^ADDR_BITS
                    rem_d  = rem_q - ONE_L;
                    if (rem_q == ONE_L) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: ;
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            out_rem_d = out_rem_q - ONE_L;
            if (out_rem_q == ONE_L) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end

        // Two-entry FIFO; the head register is the output word.
        case ({pend_q, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) s0_d = RomQ;
                else               s1_d = RomQ;
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                s0_d  = s1_q;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    s0_d = RomQ;
                end else begin
                    s0_d = s1_q;
                    s1_d = RomQ;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            out_rem_q <= '0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;   // drops any read still in flight at reset
            cnt_q     <= 2'd0;
            s0_q      <= '0;
            s1_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            out_rem_q <= out_rem_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
        end
    end

`ifdef ROMREADER_CHECKSUM_EN
    logic [DATA_BITS-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if ((state_q == S_IDLE) && Start) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + s0_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign Checksum = sum_q;
`else
    assign Checksum = '0;
`endif

    assign Busy     = (state_q != S_IDLE);
    assign Done     = done_q;
    assign RomCEB   = ~issue;
    assign RomA     = addr_q;
    assign OutValid = (cnt_q != 2'd0);
    assign OutData  = s0_q;
    assign OutLast  = OutValid && (out_rem_q == ONE_L);
    assign DbgState = state_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//   Directed bench for rom_stream_reader with a behavioural ROM, a scoreboard
//   of expected stream words and ROM addresses, and a stream monitor.
//   Honours ROMREADER_CHECKSUM_EN the same way as the design.
module tb_rom_stream_reader;

    localparam int AW = 7;
    localparam int DW = 32;
`ifdef ROMREADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic          clk;
    logic          resetn;
    logic          Start;
    logic [AW-1:0] BaseAdr;
    logic [AW:0]   Len;
    logic          Busy;
    logic          Done;
    logic          RomCEB;
    logic [AW-1:0] RomA;
    logic [DW-1:0] RomQ;
    logic          OutValid;
    logic [DW-1:0] OutData;
    logic          OutLast;
    logic          OutReady;
    logic [DW-1:0] Checksum;
    logic [1:0]    DbgState;

    logic [DW-1:0] rom [0:127];

    logic [DW-1:0] exp_q[$];
    bit            exp_last_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_sum;

    int errors = 0;
    int checks = 0;
    int issue_cnt = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    rom_stream_reader #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .Start    (Start),
        .BaseAdr  (BaseAdr),
        .Len      (Len),
        .Busy     (Busy),
        .Done     (Done),
        .RomCEB   (RomCEB),
        .RomA     (RomA),
        .RomQ     (RomQ),
        .OutValid (OutValid),
        .OutData  (OutData),
        .OutLast  (OutLast),
        .OutReady (OutReady),
        .Checksum (Checksum),
        .DbgState (DbgState)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after a RomCEB-low edge.
    always @(posedge clk) begin
        if (RomCEB == 1'b0) RomQ <= rom[RomA];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_cks();
        return CK_EN ? exp_sum : '0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit            stall_q;
        logic [DW-1:0] stall_data;
        logic [DW-1:0] w;
        logic [AW-1:0] a;
        bit            l;
        int            ahead;
        stall_q = 0;
        stall_data = '0;
        ahead = 0;
        forever begin
            @(negedge clk);
            if (resetn !== 1'b1) begin
                exp_q.delete();
                exp_last_q.delete();
                exp_addr_q.delete();
                stall_q = 0;
                ahead = 0;
            end else begin
                if (Done === 1'b1) done_cnt++;
                if (stall_q) begin
                    chk("stall_valid_hold", OutValid, 1'b1);
                    chk("stall_data_hold", OutData, stall_data);
                end
                if (RomCEB === 1'b0) begin
                    issue_cnt++;
                    ahead++;
                    chk("read_in_burst", Busy, 1'b1);
                    chk("read_expected", exp_addr_q.size() > 0, 1'b1);
                    if (exp_addr_q.size() > 0) begin
                        a = exp_addr_q.pop_front();
                        chk("rom_addr", RomA, a);
                    end
                end
                if (OutValid === 1'b1 && OutReady === 1'b1) begin
                    xfer_cnt++;
                    ahead--;
                    chk("word_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        l = exp_last_q.pop_front();
                        chk("out_data", OutData, w);
                        chk("out_last", OutLast, l);
                    end
                end
                if (RomCEB === 1'b0) chk("reads_ahead_le2", ahead <= 2, 1'b1);
                stall_q = (OutValid === 1'b1) && (OutReady !== 1'b1);
                stall_data = OutData;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] len, input bit accept);
        @(posedge clk); #1;
        Start = 1'b1;
        BaseAdr = base;
        Len = len;
        if (accept) begin
            exp_sum = '0;
            for (int i = 0; i < int'(len); i++) begin
                logic [AW-1:0] a;
                a = base + AW'(i);
                exp_addr_q.push_back(a);
                exp_q.push_back(rom[a]);
                exp_last_q.push_back(i == int'(len) - 1);
                exp_sum = exp_sum + rom[a];
            end
        end
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        bit got;
        got = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        chk({tag, "_busy_low_at_done"}, Busy, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, Busy, 1'b0);
        chk({tag, "_done"}, Done, 1'b0);
        chk({tag, "_valid"}, OutValid, 1'b0);
        chk({tag, "_last"}, OutLast, 1'b0);
        chk({tag, "_ceb"}, RomCEB, 1'b1);
        chk({tag, "_roma"}, RomA, '0);
        chk({tag, "_data"}, OutData, '0);
        chk({tag, "_cks"}, Checksum, '0);
        chk({tag, "_state"}, DbgState, 2'd0);
    endtask

    task automatic check_burst_end(input string tag);
        chk({tag, "_words_left"}, exp_q.size(), 0);
        chk({tag, "_reads_left"}, exp_addr_q.size(), 0);
        chk({tag, "_cks"}, Checksum, exp_cks());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0, i0, x0;
        bit got;
        logic [3:0] pat;

        resetn = 1'b0;
        Start = 1'b0;
        BaseAdr = '0;
        Len = '0;
        OutReady = 1'b1;
        exp_sum = '0;
        for (int i = 0; i < 128; i++) rom[i] = $urandom;
        rom[7'h60] = 32'h0000_0001;
        rom[7'h61] = 32'h0000_0002;
        rom[7'h62] = 32'hFFFF_FFFF;

        #3;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;

        // Burst at 0x10, Len 4, consumer always ready: reads on 4 back-to-back
        // cycles, first word 2 cycles after Start, Done right after OutLast.
        do_start(7'h10, 8'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_ceb_low", RomCEB, 1'b0);
            chk("t1_addr", RomA, 7'h10 + AW'(i));
            chk("t1_first_valid", OutValid, (i >= 2));
        end
        @(negedge clk);
        chk("t1_ceb_high_drain", RomCEB, 1'b1);
        @(negedge clk);
        chk("t1_last", OutLast, 1'b1);
        chk("t1_no_early_done", Done, 1'b0);
        chk("t1_busy", Busy, 1'b1);
        @(negedge clk);
        chk("t1_done", Done, 1'b1);
        chk("t1_busy_fall", Busy, 1'b0);
        check_burst_end("t1");
        @(negedge clk);
        chk("t1_done_one_cycle", Done, 1'b0);

        // Address wrap 0x7E, 0x7F, 0x00, 0x01 (addresses checked by monitor).
        do_start(7'h7E, 8'd4, 1'b1);
        wait_done("t2", 40);
        check_burst_end("t2");

        // Len 8 with OutReady pattern 1,0,0,1.
        pat = 4'b1001;
        d0 = done_cnt;
        x0 = xfer_cnt;
        do_start(7'h08, 8'd8, 1'b1);
        got = 0;
        for (int k = 0; k < 200; k++) begin
            OutReady = pat[k % 4];
            @(posedge clk); #1;
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
        end
        OutReady = 1'b1;
        chk("t3_done_seen", got, 1'b1);
        chk("t3_word_count", xfer_cnt - x0, 8);
        check_burst_end("t3");

        // Len 0: no reads, single Done pulse the next cycle, never busy.
        d0 = done_cnt;
        i0 = issue_cnt;
        do_start(7'h30, 8'd0, 1'b1);
        @(negedge clk);
        chk("t4_done", Done, 1'b1);
        chk("t4_busy", Busy, 1'b0);
        chk("t4_ceb", RomCEB, 1'b1);
        @(negedge clk);
        chk("t4_done_fall", Done, 1'b0);
        chk("t4_busy2", Busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_no_reads", issue_cnt - i0, 0);
        chk("t4_done_once", done_cnt - d0, 1);
        chk("t4_cks_cleared", Checksum, '0);

        // Start while busy is ignored.
        i0 = issue_cnt;
        x0 = xfer_cnt;
        do_start(7'h20, 8'd3, 1'b1);
        @(posedge clk); #1;
        Start = 1'b1;
        BaseAdr = 7'h50;
        Len = 8'd5;
        @(posedge clk); #1;
        Start = 1'b0;
        wait_done("t5", 40);
        check_burst_end("t5");
        repeat (4) @(negedge clk);
        chk("t5_read_count", issue_cnt - i0, 3);
        chk("t5_word_count", xfer_cnt - x0, 3);
        chk("t5_idle", Busy, 1'b0);

        // Reset mid-burst after 3 words, then a clean Len 2 burst.
        x0 = xfer_cnt;
        do_start(7'h05, 8'd8, 1'b1);
        got = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (xfer_cnt - x0 >= 3) begin
                got = 1;
                break;
            end
        end
        chk("t6_three_words", got, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check_reset("t6_reset");
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        x0 = xfer_cnt;
        do_start(7'h40, 8'd2, 1'b1);
        wait_done("t6", 40);
        check_burst_end("t6");
        repeat (3) @(negedge clk);
        chk("t6_word_count", xfer_cnt - x0, 2);

        // Checksum wrap: 1 + 2 + 0xFFFFFFFF.
        do_start(7'h60, 8'd3, 1'b1);
        wait_done("t7", 40);
        check_burst_end("t7");
        chk("t7_cks_value", Checksum, CK_EN ? 32'h0000_0002 : 32'h0);
        repeat (3) @(negedge clk);
        chk("t7_cks_hold", Checksum, CK_EN ? 32'h0000_0002 : 32'h0);

        // Full-length burst with random consumer back-pressure.
        d0 = done_cnt;
        x0 = xfer_cnt;
        do_start(7'h33, 8'd128, 1'b1);
        got = 0;
        for (int k = 0; k < 3000; k++) begin
            OutReady = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (done_cnt != d0) begin
                got = 1;
                break;
            end
        end
        OutReady = 1'b1;
        chk("t8_done_seen", got, 1'b1);
        chk("t8_word_count", xfer_cnt - x0, 128);
        check_burst_end("t8");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
